// File: rtl/ps2_scancode_rx.sv
// PS/2 keyboard receiver: synchronizes and filters the PS/2 lines, deframes
// 11-bit device-to-host frames, and resolves F0/E0 prefixes into registered
// scan codes plus a held-key tracker.
module ps2_scancode_rx #(
  parameter int FILTER_LEN  = 4,
  parameter int TIMEOUT_CYC = 5000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] scancode,
  output logic       code_valid,
  output logic       released,
  output logic       extended,
  output logic       frame_err,
  output logic [7:0] held_code,
  output logic       key_down
);

  localparam int FW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t        state, state_next;
  logic          clk_s1, clk_s2, data_s1, data_s2;
  logic          clk_filt;
  logic [FW-1:0] fcnt;
  logic          fall;
  logic [TW-1:0] tcnt;
  logic [7:0]    shreg;
  logic [2:0]    bitcnt;
  logic          par;
  logic          brk_pend, ext_pend;
  logic          byte_ok, byte_bad;

  // Two-flop synchronizers for both PS/2 lines, idle high.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      clk_s1  <= 1'b1;
      clk_s2  <= 1'b1;
      data_s1 <= 1'b1;
      data_s2 <= 1'b1;
    end else begin
      clk_s1  <= ps2_clk;
      clk_s2  <= clk_s1;
      data_s1 <= ps2_data;
      data_s2 <= data_s1;
    end
  end

  // Glitch filter on ps2_clk; emits a one-cycle fall pulse on a filtered 1->0 change.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      clk_filt <= 1'b1;
      fcnt     <= '0;
      fall     <= 1'b0;
    end else begin
      fall <= 1'b0;
      if (clk_s2 != clk_filt) begin
        if (fcnt == FW'(FILTER_LEN - 1)) begin
          clk_filt <= clk_s2;
          fcnt     <= '0;
          fall     <= clk_filt;
        end else begin
          fcnt <= fcnt + 1'b1;
        end
      end else begin
        fcnt <= '0;
      end
    end
  end

  // Inactivity counter: cleared by every fall, saturates at TIMEOUT_CYC.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      tcnt <= '0;
    end else if (fall) begin
      tcnt <= '0;
    end else if (tcnt != TW'(TIMEOUT_CYC)) begin
      tcnt <= tcnt + 1'b1;
    end
  end

  // Frame FSM state register.
  always_ff @(posedge clk) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_next;
  end

  // Next-state and frame verdict; fall takes priority since it clears the timeout counter.
  always_comb begin
    state_next = state;
    byte_ok    = 1'b0;
    byte_bad   = 1'b0;
    if (fall) begin
      unique case (state)
        S_IDLE:   if (!data_s2) state_next = S_DATA;
        S_DATA:   if (bitcnt == 3'd7) state_next = S_PARITY;
        S_PARITY: state_next = S_STOP;
        S_STOP: begin
          state_next = S_IDLE;
          if (data_s2 && (^{shreg, par})) byte_ok  = 1'b1;
          else                            byte_bad = 1'b1;
        end
        default:  state_next = S_IDLE;
      endcase
    end else if (state != S_IDLE && tcnt == TW'(TIMEOUT_CYC)) begin
      state_next = S_IDLE;
      byte_bad   = 1'b1;
    end
  end

  // Frame datapath: shift data LSB-first and capture the parity bit.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      shreg  <= '0;
      bitcnt <= '0;
      par    <= 1'b0;
    end else if (fall) begin
      unique case (state)
        S_IDLE: bitcnt <= '0;
        S_DATA: begin
          shreg  <= {data_s2, shreg[7:1]};
          bitcnt <= bitcnt + 1'b1;
        end
        S_PARITY: par <= data_s2;
        default: ;
      endcase
    end
  end

  // Prefix resolution, output registers and held-key tracking.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      scancode   <= '0;
      code_valid <= 1'b0;
      released   <= 1'b0;
      extended   <= 1'b0;
      frame_err  <= 1'b0;
      held_code  <= '0;
      key_down   <= 1'b0;
      brk_pend   <= 1'b0;
      ext_pend   <= 1'b0;
    end else begin
      code_valid <= 1'b0;
      frame_err  <= 1'b0;
      if (byte_bad) begin
        frame_err <= 1'b1;
        brk_pend  <= 1'b0;
        ext_pend  <= 1'b0;
      end else if (byte_ok) begin
        if (shreg == 8'hF0) begin
          brk_pend <= 1'b1;
        end else if (shreg == 8'hE0) begin
          ext_pend <= 1'b1;
        end else begin
          scancode   <= shreg;
          released   <= brk_pend;
          extended   <= ext_pend;
          code_valid <= 1'b1;
          brk_pend   <= 1'b0;
          ext_pend   <= 1'b0;
          if (!brk_pend) begin
            held_code <= shreg;
            key_down  <= 1'b1;
          end else if (shreg == held_code) begin
            key_down <= 1'b0;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_ps2_scancode_rx.sv
// Directed bench for ps2_scancode_rx: bit-bangs PS/2 frames and checks the
// decoded outputs against hand-computed values.
module tb_ps2_scancode_rx;

  localparam int FL = 4;
  localparam int TO = 400;

  logic       clk, reset_n, ps2_clk, ps2_data;
  logic [7:0] scancode, held_code;
  logic       code_valid, released, extended, frame_err, key_down;

  int total = 0;
  int bad   = 0;
  int cv_cnt = 0, err_cnt = 0, both_cnt = 0, wide_cnt = 0;
  logic cv_prev = 1'b0, err_prev = 1'b0;
  int cv0, err0;

  ps2_scancode_rx #(.FILTER_LEN(FL), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .reset_n(reset_n), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .scancode(scancode), .code_valid(code_valid), .released(released),
    .extended(extended), .frame_err(frame_err), .held_code(held_code),
    .key_down(key_down)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #20ms;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  // Pulse monitor sampled on the inactive edge.
  always @(negedge clk) begin
    if (code_valid) cv_cnt++;
    if (frame_err) err_cnt++;
    if (code_valid && frame_err) both_cnt++;
    if ((code_valid && cv_prev) || (frame_err && err_prev)) wide_cnt++;
    cv_prev  = code_valid;
    err_prev = frame_err;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b, input bit glitch);
    ps2_data = b;
    tick(10);
    ps2_clk = 1'b0;
    tick(20);
    ps2_clk = 1'b1;
    if (glitch) begin
      tick(8);
      ps2_clk = 1'b0;
      tick(FL - 1);
      ps2_clk = 1'b1;
    end
    tick(10);
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_par,
                            input int glitch_bit, input int nbits);
    logic [10:0] fr;
    fr = {1'b1, (~^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < nbits; i++) send_bit(fr[i], i == glitch_bit);
    ps2_data = 1'b1;
    tick(20);
  endtask

  task automatic snap;
    cv0  = cv_cnt;
    err0 = err_cnt;
  endtask

  task automatic test_reset;
    total++; if (scancode !== 8'h00) begin bad++; $display("FAIL rst_scancode got=%h exp=00", scancode); end
    total++; if ({code_valid, released, extended, frame_err, key_down} !== 5'b0) begin bad++; $display("FAIL rst_flags got=%b exp=00000", {code_valid, released, extended, frame_err, key_down}); end
    total++; if (held_code !== 8'h00) begin bad++; $display("FAIL rst_held got=%h exp=00", held_code); end
  endtask

  task automatic test_make;
    snap();
    send_frame(8'h1C, 0, -1, 11);
    total++; if (cv_cnt - cv0 !== 1) begin bad++; $display("FAIL make_cv_count got=%0d exp=1", cv_cnt - cv0); end
    total++; if (err_cnt - err0 !== 0) begin bad++; $display("FAIL make_err_count got=%0d exp=0", err_cnt - err0); end
    total++; if (scancode !== 8'h1C) begin bad++; $display("FAIL make_scancode got=%h exp=1c", scancode); end
    total++; if ({released, extended, key_down} !== 3'b001) begin bad++; $display("FAIL make_flags got=%b exp=001", {released, extended, key_down}); end
    total++; if (held_code !== 8'h1C) begin bad++; $display("FAIL make_held got=%h exp=1c", held_code); end
  endtask

  task automatic test_break;
    snap();
    send_frame(8'hF0, 0, -1, 11);
    send_frame(8'h1C, 0, -1, 11);
    total++; if (cv_cnt - cv0 !== 1) begin bad++; $display("FAIL break_cv_count got=%0d exp=1", cv_cnt - cv0); end
    total++; if (scancode !== 8'h1C) begin bad++; $display("FAIL break_scancode got=%h exp=1c", scancode); end
    total++; if ({released, key_down} !== 2'b10) begin bad++; $display("FAIL break_flags got=%b exp=10", {released, key_down}); end
  endtask

  task automatic test_parity_err;
    send_frame(8'h1C, 0, -1, 11);
    snap();
    send_frame(8'h32, 1, -1, 11);
    total++; if (err_cnt - err0 !== 1) begin bad++; $display("FAIL par_err_count got=%0d exp=1", err_cnt - err0); end
    total++; if (cv_cnt - cv0 !== 0) begin bad++; $display("FAIL par_cv_count got=%0d exp=0", cv_cnt - cv0); end
    total++; if (held_code !== 8'h1C) begin bad++; $display("FAIL par_held got=%h exp=1c", held_code); end
    send_frame(8'hF0, 0, -1, 11);
    send_frame(8'h32, 0, -1, 11);
    total++; if (scancode !== 8'h32) begin bad++; $display("FAIL brk_other_scancode got=%h exp=32", scancode); end
    total++; if ({released, key_down} !== 2'b11) begin bad++; $display("FAIL brk_other_flags got=%b exp=11", {released, key_down}); end
    total++; if (held_code !== 8'h1C) begin bad++; $display("FAIL brk_other_held got=%h exp=1c", held_code); end
    send_frame(8'hF0, 0, -1, 11);
    send_frame(8'h32, 1, -1, 11);
    send_frame(8'h1C, 0, -1, 11);
    total++; if ({released, key_down} !== 2'b01) begin bad++; $display("FAIL err_clears_pend got=%b exp=01", {released, key_down}); end
  endtask

  task automatic test_extended;
    send_frame(8'hE0, 0, -1, 11);
    send_frame(8'h75, 0, -1, 11);
    total++; if (scancode !== 8'h75) begin bad++; $display("FAIL ext_scancode got=%h exp=75", scancode); end
    total++; if ({extended, released, key_down} !== 3'b101) begin bad++; $display("FAIL ext_flags got=%b exp=101", {extended, released, key_down}); end
    total++; if (held_code !== 8'h75) begin bad++; $display("FAIL ext_held got=%h exp=75", held_code); end
    send_frame(8'h21, 0, -1, 11);
    total++; if ({scancode, extended} !== {8'h21, 1'b0}) begin bad++; $display("FAIL plain_after_ext got=%h/%b exp=21/0", scancode, extended); end
    snap();
    send_frame(8'hE0, 0, -1, 11);
    send_frame(8'hF0, 0, -1, 11);
    send_frame(8'hF0, 0, -1, 11);
    send_frame(8'hE0, 0, -1, 11);
    send_frame(8'h21, 0, -1, 11);
    total++; if (cv_cnt - cv0 !== 1) begin bad++; $display("FAIL repeat_prefix_cv got=%0d exp=1", cv_cnt - cv0); end
    total++; if ({extended, released, key_down} !== 3'b110) begin bad++; $display("FAIL repeat_prefix_flags got=%b exp=110", {extended, released, key_down}); end
  endtask

  task automatic test_timeout;
    snap();
    send_frame(8'h00, 0, -1, 6);
    tick(TO + 10);
    total++; if (err_cnt - err0 !== 1) begin bad++; $display("FAIL timeout_err got=%0d exp=1", err_cnt - err0); end
    total++; if (cv_cnt - cv0 !== 0) begin bad++; $display("FAIL timeout_cv got=%0d exp=0", cv_cnt - cv0); end
    snap();
    send_frame(8'h21, 0, -1, 11);
    total++; if (cv_cnt - cv0 !== 1 || err_cnt - err0 !== 0) begin bad++; $display("FAIL after_timeout_counts got=%0d/%0d exp=1/0", cv_cnt - cv0, err_cnt - err0); end
    total++; if ({scancode, released, key_down} !== {8'h21, 2'b01}) begin bad++; $display("FAIL after_timeout_code got=%h/%b%b exp=21/01", scancode, released, key_down); end
  endtask

  task automatic test_glitch;
    snap();
    send_frame(8'h45, 0, 3, 11);
    total++; if (cv_cnt - cv0 !== 1 || err_cnt - err0 !== 0) begin bad++; $display("FAIL glitch_counts got=%0d/%0d exp=1/0", cv_cnt - cv0, err_cnt - err0); end
    total++; if (scancode !== 8'h45) begin bad++; $display("FAIL glitch_scancode got=%h exp=45", scancode); end
  endtask

  task automatic test_mid_reset;
    send_frame(8'h5A, 0, -1, 5);
    reset_n = 1'b0;
    tick(1);
    reset_n = 1'b1;
    total++; if ({scancode, held_code} !== 16'h0000) begin bad++; $display("FAIL midrst_codes got=%h/%h exp=00/00", scancode, held_code); end
    total++; if ({code_valid, released, extended, frame_err, key_down} !== 5'b0) begin bad++; $display("FAIL midrst_flags got=%b exp=00000", {code_valid, released, extended, frame_err, key_down}); end
    tick(20);
    snap();
    send_frame(8'h16, 0, -1, 11);
    total++; if (cv_cnt - cv0 !== 1 || err_cnt - err0 !== 0) begin bad++; $display("FAIL midrst_counts got=%0d/%0d exp=1/0", cv_cnt - cv0, err_cnt - err0); end
    total++; if ({scancode, held_code, key_down, released} !== {8'h16, 8'h16, 2'b10}) begin bad++; $display("FAIL midrst_decode got=%h/%h/%b%b exp=16/16/10", scancode, held_code, key_down, released); end
  endtask

  task automatic test_pulse_shape;
    total++; if (both_cnt !== 0) begin bad++; $display("FAIL pulse_overlap got=%0d exp=0", both_cnt); end
    total++; if (wide_cnt !== 0) begin bad++; $display("FAIL pulse_width got=%0d exp=0", wide_cnt); end
  endtask

  initial begin
    reset_n  = 1'b0;
    ps2_clk  = 1'b1;
    ps2_data = 1'b1;
    tick(5);
    reset_n = 1'b1;
    tick(5);
    test_reset();
    test_make();
    test_break();
    test_parity_err();
    test_extended();
    test_timeout();
    test_glitch();
    test_mid_reset();
    test_pulse_shape();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ps2_scancode_rx.md
# ps2_scancode_rx

Receives the device-to-host PS/2 keyboard serial stream and turns it into registered scan codes. It runs the 11-bit PS/2 frame state machine, resolves the `F0` (break) and `E0` (extended) prefixes, and tracks the last key held down. Its `held_code`/`key_down` pair drives the scan-code-to-seven-segment letter decoder: `held_code[6:0]` feeds the scan-code input and `key_down` feeds the enable flag.

## Interface
Parameters:
- `FILTER_LEN`, 4: system clocks `ps2_clk` must be stable before a level change is accepted.
- `TIMEOUT_CYC`, 5000: system clocks without a filtered `ps2_clk` falling edge before a partial frame is aborted (100 µs at 50 MHz).

Ports:
- `clk` in 1: system clock. One clock domain only.
- `reset_n` in 1: reset, synchronous and active-low.
- `ps2_clk` in 1: PS/2 clock from the keyboard, asynchronous.
- `ps2_data` in 1: PS/2 data from the keyboard, asynchronous.
- `scancode` out 8: last decoded non-prefix byte.
- `code_valid` out 1: one-cycle pulse when `scancode`, `released` and `extended` update.
- `released` out 1: the byte was preceded by `F0`.
- `extended` out 1: the byte was preceded by `E0`.
- `frame_err` out 1: one-cycle pulse on a parity, stop-bit or timeout error.
- `held_code` out 8: code of the key currently or last held.
- `key_down` out 1: 1 while `held_code` is pressed.

## Operation
Input conditioning:
- `ps2_clk` and `ps2_data` each pass through a 2-FF synchronizer.
- `ps2_clk` is then filtered: the filtered level changes only after `FILTER_LEN` consecutive equal synchronized samples.
- A falling edge of the filtered clock gives a one-cycle `fall` pulse.
- Data is sampled from synchronized `ps2_data` in the `fall` cycle.

Frame FSM:
- IDLE: on `fall` with data=0, go to DATA and clear `bitcnt`. On `fall` with data=1, stay in IDLE; no error.
- DATA: shift the data bit in LSB-first; `bitcnt` increments. After bit 7, go to PARITY.
- PARITY: store the bit, go to STOP.
- STOP: check the frame, go to IDLE.
  - Valid frame: stop=1 and XOR of (8 data bits, parity) = 1 (odd parity).
  - Valid frame passes the byte to the prefix stage.
  - Invalid frame pulses `frame_err` and discards the byte.
- Timeout: a cycle counter clears on every `fall`. If it reaches `TIMEOUT_CYC` in any state except IDLE, go to IDLE, pulse `frame_err`, and discard the partial byte. The counter saturates; it never wraps.

Prefix stage, per valid byte:
- `F0`: set `brk_pend`; no `code_valid`.
- `E0`: set `ext_pend`; no `code_valid`.
- Any other byte:
  - Load `scancode` with the byte, `released` with `brk_pend`, `extended` with `ext_pend`.
  - Pulse `code_valid`, then clear both pending flags.
  - Make (`brk_pend`=0): `held_code`=byte, `key_down`=1.
  - Break (`brk_pend`=1): if byte == `held_code`, then `key_down`=0. Otherwise `held_code`/`key_down` are unchanged.
- Repeated `F0`/`E0` bytes are idempotent.
- `frame_err` clears `brk_pend` and `ext_pend`.

## Timing
- Reset values: all outputs 0, FSM in IDLE, both pending flags 0, synchronizers and filter loaded to 1 (line idle).
- Reset wins over every other event in the same cycle. A mid-frame reset discards the frame; the next start bit begins a fresh frame.
- Latency:
  - `fall` trails the physical `ps2_clk` edge by 2 synchronizer cycles plus `FILTER_LEN`.
  - `code_valid` and `frame_err` are high in the cycle after the STOP-bit `fall` cycle.
  - All outputs update in that same cycle.
- `code_valid` and `frame_err` are never high together. Each is exactly one cycle wide.
- `scancode`, `released`, `extended` and `held_code` hold their values until the next update.
- A timeout in the same cycle as `fall` does not occur, because `fall` clears the counter first.
- There is no backpressure. The consumer samples on `code_valid`.

## Test plan
1. Frame 0x1C: start 0; data 0,0,1,1,1,0,0,0; parity 0; stop 1 -> one `code_valid` with `scancode`=8'h1C, `released`=0, `extended`=0, `key_down`=1, `held_code`=8'h1C.
2. Frames F0 then 1C after test 1 -> exactly one `code_valid`, with `scancode`=8'h1C, `released`=1, `key_down`=0.
3. Frame 0x32 with parity bit 1 (correct is 0) -> `frame_err` pulse, no `code_valid`, `held_code` unchanged. Then frame F0 then 32 -> `released`=1, `key_down` unchanged because 8'h32 ≠ `held_code`.
4. Frames E0 then 75 -> `scancode`=8'h75, `extended`=1, `released`=0. A following plain 0x21 -> `extended`=0.
5. Stop `ps2_clk` after 5 data bits; wait `TIMEOUT_CYC`+10 cycles -> one `frame_err` pulse, FSM in IDLE. A clean 0x21 frame then decodes to `scancode`=8'h21.
6. Low glitch on `ps2_clk` of `FILTER_LEN`-1 cycles mid-frame -> ignored, and frame 0x45 still decodes. Assert `reset_n`=0 for 1 cycle after bit 3 of a frame -> all outputs 0, and the next full 0x16 frame decodes correctly.
